running_max: RTL and testbench

- Sits directly downstream of the Q·K dot-product stage and upstream of the exp/multiply-accumulate stage.
- Consumes one scaled score s plus its matching V vector per key row and tracks the online-softmax running maximum m across the SEQ_LEN rows of each query.
- Emits, per row, the score difference (s − m_new), the max correction (m_old − m_new) and the pass-through V vector, with first/last-row markers.

---
 rtl/running_max.sv | 179 +++++++++++++++++
 tb/tb_running_max.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/running_max.sv
// rtl/running_max.sv - online-softmax running maximum stage between Q.K dot product and exp/MAC
// Optional feature macro: RUNNING_MAX_SAT_CNT_EN (adds 16-bit sat_cnt_out saturation event counter)
module running_max #(
    parameter int S_W     = 9,
    parameter int V_W     = 512,
    parameter int SEQ_LEN = 64,
    parameter int CNT_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_in,
    output logic                  rdy_out,
    input  logic signed [S_W-1:0] s_in,
    input  logic [V_W-1:0]        v_in,
    input  logic                  rdy_in,
    output logic                  vld_out,
    output logic signed [S_W-1:0] s_diff_out,
    output logic signed [S_W-1:0] m_diff_out,
    output logic signed [S_W-1:0] m_out,
    output logic [V_W-1:0]        v_out,
    output logic                  first_out,
    output logic                  last_out
`ifdef RUNNING_MAX_SAT_CNT_EN
    ,
    output logic [15:0]           sat_cnt_out
`endif
);

    // Most negative score: forced max correction on a query's first row so downstream exp() yields 0
    localparam logic signed [S_W-1:0] S_MIN    = {1'b1, {(S_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    vld_q, vld_d;
    logic signed [S_W-1:0]   s_diff_q, s_diff_d;
    logic signed [S_W-1:0]   m_diff_q, m_diff_d;
    logic signed [S_W-1:0]   m_q, m_d;
    logic [V_W-1:0]          v_q, v_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;

    logic                    accept;
    logic signed [S_W-1:0]   m_max;
    logic [S_W:0]            s_ext, m_ext, mx_ext;
    logic [S_W:0]            s_raw, m_raw;

    // Differences are never positive and never below -(2^S_W - 1), so overflow is always
    // negative and shows up as the two top bits of the widened result disagreeing.
    function automatic logic signed [S_W-1:0] sat_diff(input logic [S_W:0] d);
        if (d[S_W] != d[S_W-1]) begin
            return S_MIN;
        end
        return d[S_W-1:0];
    endfunction

    assign rdy_out    = !vld_q || rdy_in;
    assign vld_out    = vld_q;
    assign s_diff_out = s_diff_q;
    assign m_diff_out = m_diff_q;
    assign m_out      = m_q;
    assign v_out      = v_q;
    assign first_out  = first_q;
    assign last_out   = last_q;

    // Datapath: widened subtractions against the updated running max
    always_comb begin
        accept = vld_in && rdy_out;
        m_max  = (s_in >= m_q) ? s_in : m_q;
        s_ext  = {s_in[S_W-1], s_in};
        m_ext  = {m_q[S_W-1], m_q};
        mx_ext = {m_max[S_W-1], m_max};
        s_raw  = s_ext - mx_ext;
        m_raw  = m_ext - mx_ext;
    end

    // Next-state: FIRST/MID row sequencing plus output register load/hold/clear
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        s_diff_d = s_diff_q;
        m_diff_d = m_diff_q;
        m_d      = m_q;
        v_d      = v_q;
        first_d  = first_q;
        last_d   = last_q;

        if (accept) begin
            vld_d = 1'b1;
        end else if (rdy_in) begin
            vld_d = 1'b0;
        end

        if (accept) begin
            v_d = v_in;
            case (state_q)
                ST_FIRST: begin
                    m_d      = s_in;
                    s_diff_d = '0;
                    m_diff_d = S_MIN;
                    first_d  = 1'b1;
                    cnt_d    = CNT_LAST;
                    last_d   = (SEQ_LEN == 1);
                    state_d  = (SEQ_LEN == 1) ? ST_FIRST : ST_MID;
                end
                ST_MID: begin
                    m_d      = m_max;
                    s_diff_d = sat_diff(s_raw);
                    m_diff_d = sat_diff(m_raw);
                    first_d  = 1'b0;
                    cnt_d    = cnt_q - CNT_ONE;
                    last_d   = (cnt_q == CNT_ONE);
                    state_d  = (cnt_q == CNT_ONE) ? ST_FIRST : ST_MID;
                end
                default: begin
                    state_d = ST_FIRST;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial query
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_FIRST;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            s_diff_q <= '0;
            m_diff_q <= '0;
            m_q      <= '0;
            v_q      <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            s_diff_q <= s_diff_d;
            m_diff_q <= m_diff_d;
            m_q      <= m_d;
            v_q      <= v_d;
            first_q  <= first_d;
            last_q   <= last_d;
        end
    end

`ifdef RUNNING_MAX_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        row_sat;

    // Count MID rows whose difference clamped; the forced FIRST-row correction is not a clamp
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        row_sat   = (s_raw[S_W] != s_raw[S_W-1]) || (m_raw[S_W] != m_raw[S_W-1]);
        if (accept && (state_q == ST_MID) && row_sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_out = sat_cnt_q;
`endif

endmodule

// File: tb/tb_running_max.sv
// tb/tb_running_max.sv - directed and randomized self-checking bench for running_max
module tb_running_max;

    localparam int S_W = 9;
    localparam int V_W = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  vld_in = 1'b0;
    logic                  rdy_in = 1'b1;
    logic signed [S_W-1:0] s_in = '0;
    logic [V_W-1:0]        v_in = '0;

    logic                  rdy_out, vld_out, first_out, last_out;
    logic signed [S_W-1:0] s_diff_out, m_diff_out, m_out;
    logic [V_W-1:0]        v_out;

    logic                  o1_rdy, o1_vld, o1_first, o1_last;
    logic signed [S_W-1:0] o1_sd, o1_md, o1_m;
    logic [V_W-1:0]        o1_v;

`ifdef RUNNING_MAX_SAT_CNT_EN
    logic [15:0] sat_cnt_out, o1_sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int             sd;
        int             md;
        int             m;
        logic [V_W-1:0] v;
        logic           first;
        logic           last;
    } exp_t;

    running_max #(.S_W(S_W), .V_W(V_W), .SEQ_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .s_in(s_in), .v_in(v_in),
        .rdy_in(rdy_in), .vld_out(vld_out), .s_diff_out(s_diff_out), .m_diff_out(m_diff_out),
        .m_out(m_out), .v_out(v_out), .first_out(first_out), .last_out(last_out)
`ifdef RUNNING_MAX_SAT_CNT_EN
        , .sat_cnt_out(sat_cnt_out)
`endif
    );

    running_max #(.S_W(S_W), .V_W(V_W), .SEQ_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(o1_rdy), .s_in(s_in), .v_in(v_in),
        .rdy_in(rdy_in), .vld_out(o1_vld), .s_diff_out(o1_sd), .m_diff_out(o1_md),
        .m_out(o1_m), .v_out(o1_v), .first_out(o1_first), .last_out(o1_last)
`ifdef RUNNING_MAX_SAT_CNT_EN
        , .sat_cnt_out(o1_sat)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; vld_in = 1'b0; rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Present one row at a negedge; returns at the negedge after the accepting posedge
    task automatic drive_row(input int s, input logic [V_W-1:0] v);
        vld_in = 1'b1; s_in = S_W'(s); v_in = v;
        @(posedge clk);
        @(negedge clk);
        vld_in = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; vld_in = 1'b1; s_in = 9'sd5; v_in = 32'hDEAD;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({vld_out, s_diff_out, m_diff_out, m_out, v_out, first_out, last_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b sd=%0d md=%0d m=%0d v=%h f=%b l=%b, want all zero",
                     vld_out, s_diff_out, m_diff_out, m_out, v_out, first_out, last_out);
        end
        n_checks++;
        if (rdy_out !== 1'b1 || o1_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got rdy_out=%b o1_vld=%b, want 1 0", rdy_out, o1_vld);
        end
        vld_in = 1'b0; rst = 1'b1;
    endtask

    task automatic test_basic();
        int sc[4]  = '{10, 20, 15, 30};
        int esd[4] = '{0, 0, -5, 0};
        int emd[4] = '{-256, -10, 0, -10};
        int em[4]  = '{10, 20, 20, 30};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_row(sc[i], 32'hA000 + i);
            n_checks++;
            if ({vld_out, s_diff_out, m_diff_out, m_out, first_out, last_out, v_out} !==
                {1'b1, S_W'(esd[i]), S_W'(emd[i]), S_W'(em[i]), (i == 0), (i == 3), 32'hA000 + i}) begin
                n_fail++;
                $display("FAIL basic row %0d: got vld=%b sd=%0d md=%0d m=%0d f=%b l=%b v=%h, want 1 %0d %0d %0d %b %b %h",
                         i, vld_out, s_diff_out, m_diff_out, m_out, first_out, last_out, v_out,
                         esd[i], emd[i], em[i], (i == 0), (i == 3), 32'hA000 + i);
            end
        end
        drive_row(7, 32'hA004);
        n_checks++;
        if ({first_out, last_out, s_diff_out, m_diff_out, m_out} !== {1'b1, 1'b0, 9'sd0, -9'sd256, 9'sd7}) begin
            n_fail++;
            $display("FAIL basic_next_first: got f=%b l=%b sd=%0d md=%0d m=%0d, want 1 0 0 -256 7",
                     first_out, last_out, s_diff_out, m_diff_out, m_out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive_row(1, 32'hB000);
        vld_in = 1'b1; s_in = 9'sd2; v_in = 32'hB001; rdy_in = 1'b0;
        #1;
        n_checks++;
        if (rdy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_rdy_low: got rdy_out=%b, want 0", rdy_out);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({rdy_out, vld_out, v_out, s_diff_out, m_out} !== {1'b0, 1'b1, 32'hB000, 9'sd0, 9'sd1}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got rdy=%b vld=%b v=%h sd=%0d m=%0d, want 0 1 b000 0 1",
                         c, rdy_out, vld_out, v_out, s_diff_out, m_out);
            end
        end
        rdy_in = 1'b1;
        for (int r = 1; r < 4; r++) begin
            s_in = S_W'(r + 1); v_in = 32'hB000 + r;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({vld_out, v_out, s_diff_out, m_diff_out, m_out, first_out, last_out} !==
                {1'b1, 32'hB000 + r, 9'sd0, -9'sd1, S_W'(r + 1), 1'b0, (r == 3)}) begin
                n_fail++;
                $display("FAIL bp_release row %0d: got vld=%b v=%h sd=%0d md=%0d m=%0d f=%b l=%b, want 1 %h 0 -1 %0d 0 %b",
                         r, vld_out, v_out, s_diff_out, m_diff_out, m_out, first_out, last_out,
                         32'hB000 + r, r + 1, (r == 3));
            end
        end
        vld_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got vld_out=%b, want 0", vld_out);
        end
    endtask

    task automatic test_saturation();
        int sc[6]  = '{255, -256, 255, 0, -256, 255};
        int esd[6] = '{0, -256, 0, -255, 0, 0};
        int emd[6] = '{-256, 0, 0, 0, -256, -256};
        int em[6]  = '{255, 255, 255, 255, -256, 255};
        int esat[6] = '{0, 1, 1, 1, 1, 2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_row(sc[i], 32'hC000 + i);
            n_checks++;
            if ({s_diff_out, m_diff_out, m_out, first_out, last_out} !==
                {S_W'(esd[i]), S_W'(emd[i]), S_W'(em[i]), (i == 0 || i == 4), (i == 3)}) begin
                n_fail++;
                $display("FAIL sat row %0d: got sd=%0d md=%0d m=%0d f=%b l=%b, want %0d %0d %0d %b %b",
                         i, s_diff_out, m_diff_out, m_out, first_out, last_out,
                         esd[i], emd[i], em[i], (i == 0 || i == 4), (i == 3));
            end
`ifdef RUNNING_MAX_SAT_CNT_EN
            n_checks++;
            if (sat_cnt_out !== 16'(esat[i])) begin
                n_fail++;
                $display("FAIL sat_cnt row %0d: got %0d, want %0d", i, sat_cnt_out, esat[i]);
            end
`else
            if (esat[i] < 0) $display("unused %0d", esat[i]);
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_row(10, 32'hD000);
        drive_row(20, 32'hD001);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_vld: got vld_out=%b, want 0", vld_out);
        end
        rst = 1'b1;
        drive_row(5, 32'hD002);
        n_checks++;
        if ({vld_out, first_out, last_out, s_diff_out, m_diff_out, m_out} !==
            {1'b1, 1'b1, 1'b0, 9'sd0, -9'sd256, 9'sd5}) begin
            n_fail++;
            $display("FAIL reset_mid_first: got vld=%b f=%b l=%b sd=%0d md=%0d m=%0d, want 1 1 0 0 -256 5",
                     vld_out, first_out, last_out, s_diff_out, m_diff_out, m_out);
        end
    endtask

    task automatic test_seq1();
        int sc[4] = '{-3, 100, -256, 100};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_row(sc[i], 32'hE000 + i);
            n_checks++;
            if ({o1_vld, o1_first, o1_last, o1_sd, o1_md, o1_m, o1_v} !==
                {1'b1, 1'b1, 1'b1, 9'sd0, -9'sd256, S_W'(sc[i]), 32'hE000 + i}) begin
                n_fail++;
                $display("FAIL seq1 row %0d: got vld=%b f=%b l=%b sd=%0d md=%0d m=%0d v=%h, want 1 1 1 0 -256 %0d %h",
                         i, o1_vld, o1_first, o1_last, o1_sd, o1_md, o1_m, o1_v, sc[i], 32'hE000 + i);
            end
        end
`ifdef RUNNING_MAX_SAT_CNT_EN
        n_checks++;
        if (o1_sat !== 16'd0) begin
            n_fail++;
            $display("FAIL seq1_sat_cnt: got %0d, want 0", o1_sat);
        end
`endif
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int   sent = 0, got = 0, cyc = 0, row = 0, m_model = 0, sat_model = 0;
        int   si, mn, dsd, dmd;
        logic holding = 1'b0;
        logic out_hs, acc;
        do_reset();
        while (got < 400 && cyc < 6000) begin
            if (!holding) begin
                if (sent < 400 && $urandom_range(0, 2) != 0) begin
                    vld_in = 1'b1;
                    s_in   = S_W'($urandom_range(0, 511));
                    v_in   = $urandom;
                end else begin
                    vld_in = 1'b0;
                end
            end
            rdy_in = ($urandom_range(0, 3) != 0);
            #1;
            out_hs = vld_out && rdy_in;
            acc    = vld_in && rdy_out;
            if (out_hs) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_output: got output %0d with nothing outstanding, want none", got);
                end else begin
                    e = q.pop_front();
                    if ({s_diff_out, m_diff_out, m_out, v_out, first_out, last_out} !==
                        {S_W'(e.sd), S_W'(e.md), S_W'(e.m), e.v, e.first, e.last}) begin
                        n_fail++;
                        $display("FAIL rand out %0d: got sd=%0d md=%0d m=%0d v=%h f=%b l=%b, want %0d %0d %0d %h %b %b",
                                 got, s_diff_out, m_diff_out, m_out, v_out, first_out, last_out,
                                 e.sd, e.md, e.m, e.v, e.first, e.last);
                    end
                end
                got++;
            end
            if (acc) begin
                si  = int'(s_in);
                e.v = v_in;
                if (row == 0) begin
                    m_model = si;
                    e.sd = 0; e.md = -256; e.m = si; e.first = 1'b1;
                end else begin
                    mn  = (si > m_model) ? si : m_model;
                    dsd = si - mn;
                    dmd = m_model - mn;
                    if (dsd < -256 || dmd < -256) sat_model++;
                    e.sd = (dsd < -256) ? -256 : dsd;
                    e.md = (dmd < -256) ? -256 : dmd;
                    e.m  = mn;
                    e.first = 1'b0;
                    m_model = mn;
                end
                e.last = (row == 3);
                row = (row + 1) % 4;
                q.push_back(e);
                sent++;
            end
            holding = vld_in && !acc;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        vld_in = 1'b0;
        n_checks++;
        if (got != 400 || sent != 400 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got outputs=%0d accepts=%0d outstanding=%0d, want 400 400 0",
                     got, sent, q.size());
        end
`ifdef RUNNING_MAX_SAT_CNT_EN
        n_checks++;
        if (sat_cnt_out !== 16'(sat_model)) begin
            n_fail++;
            $display("FAIL rand_sat_cnt: got %0d, want %0d", sat_cnt_out, sat_model);
        end
`else
        if (sat_model < 0) $display("unused %0d", sat_model);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_seq1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
